dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Memory-stage initiator for the Y86-64 pipeline. Decodes M_icode and issues one read or
//  write per instruction to the data memory over a req/ack handshake. Returns valM, stalls
//  the pipeline while an access is outstanding, and flags dmem_error on a bad address or
//  a timeout. Sits between the M pipeline register and data_memory.
// PARAMETERS
//  MEM_DEPTH  8192  number of 64-bit words; a valid address satisfies addr < MEM_DEPTH
//  TIMEOUT    16    cycles to wait for mem_ack before flagging an error (>=1)
//  TO_W       5     timeout counter width; must satisfy 2^TO_W > TIMEOUT
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  M_valid      in   1   M stage holds a real (non-bubble) instruction
//  M_icode      in   4   instruction code
//  M_valE       in   64  ALU result (address for rmmovq/mrmovq/call/pushq)
//  M_valA       in   64  store data, or address for popq/ret
//  mem_req      out  1   request valid (registered)
//  mem_read     out  1   read request (registered)
//  mem_write    out  1   write request (registered)
//  mem_addr     out  64  request address (registered)
//  mem_wdata    out  64  write data (registered)
//  mem_ack      in   1   responder completion; sampled only while mem_req=1
//  mem_rdata    in   64  read data, valid in the same cycle as mem_ack
//  m_valM       out  64  captured read data (registered)
//  m_done       out  1   one-cycle pulse: access complete
//  m_stall      out  1   stall F/D/E/M (combinational)
//  dmem_error   out  1   sticky error flag (registered)
// BEHAVIOUR
//  Decode: icode 4 (rmmovq) writes valA to valE. Icode 8 (call) and A (pushq) write valA
//   to valE. Icode 5 (mrmovq) reads valE. Icode 9 (ret) and B (popq) read valA. Every
//   other icode, or M_valid=0, is not a memory operation (no-op).
//  Reset: state=IDLE, mem_req/read/write=0, mem_addr/mem_wdata/m_valM=0, m_done=0,
//   dmem_error=0, timeout counter=0. Reset mid-access aborts the access; mem_req falls
//   immediately.
//  IDLE: if the instruction is a memory operation and the address is < MEM_DEPTH, register
//   addr/wdata/read/write and set mem_req=1, then go to BUSY. If the address is out of
//   range, set dmem_error=1, issue no request and stay in IDLE. For a no-op, outputs hold
//   and m_valM keeps its last value.
//  BUSY: mem_req, mem_addr, mem_wdata and the direction bits stay stable. Each cycle
//   without ack increments the counter. At the edge where mem_ack=1:
//   - if read: m_valM <= mem_rdata;
//   - mem_req/mem_read/mem_write <= 0; m_done <= 1; counter <= 0;
//   - go to DONE.
//   If the counter reaches TIMEOUT with no ack, drop mem_req, set dmem_error=1 and go to
//   IDLE with no m_done.
//  DONE: m_done=1 for exactly this cycle, then go to IDLE. The M register advances here.
//  m_stall = (IDLE & start) | BUSY. It is 0 in DONE and after an address error.
//  Latency: ack in the first BUSY cycle gives request-to-done = 2 cycles, and stall lasts
//   2 cycles.
//  M inputs are ignored in BUSY and DONE; the stall holds them.
//  mem_read and mem_write are never both 1. mem_ack while mem_req=0 is ignored.
//  dmem_error is sticky until reset. The request is not retried.
// TESTING
//  1 mrmovq, valE=0x10, ack one cycle after req, rdata=0xDEADBEEF -> mem_read=1,
//    addr=0x10; m_valM=0xDEADBEEF; m_done pulses once; m_stall high 2 cycles.
//  2 pushq, valE=0x1FF8/8 word, valA=0x55 -> mem_write=1, wdata=0x55, mem_read=0;
//    ack delayed 5 cycles -> stall high 6 cycles, then m_done.
//  3 nop / M_valid=0 / opq -> mem_req stays 0, m_stall=0, m_valM unchanged.
//  4 rmmovq, valE=8192 -> no mem_req, dmem_error=1 next edge, m_stall=0.
//  5 popq, ack never arrives, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles;
//    dmem_error=1; no m_done.
//  6 rst_n low in BUSY -> mem_req=0 immediately; after release the next mrmovq works
//    normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Memory-stage initiator for the Y86-64 pipeline.
// Decodes M_icode, issues one read or write to the data memory over a req/ack
// handshake, captures valM, and stalls the pipeline while the access is outstanding.
// Bad addresses and missing acks raise a sticky dmem_error; requests are never retried.
module dmem_access_ctrl #(
  parameter int MEM_DEPTH = 8192,
  parameter int TIMEOUT   = 16,
  parameter int TO_W      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_valid,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] m_valM,
  output logic        m_done,
  output logic        m_stall,
  output logic        dmem_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            op_rd;
  logic            op_wr;
  logic            op_mem;
  logic [63:0]     op_addr;
  logic            addr_ok;
  logic            start;
  logic            ack_hit;
  logic            to_hit;
  logic [TO_W-1:0] cnt;

  // Decode the M-stage instruction into direction and address source
  always_comb begin
    op_rd   = 1'b0;
    op_wr   = 1'b0;
    op_addr = M_valE;
    if (M_valid) begin
      case (M_icode)
        4'h4, 4'h8, 4'hA: op_wr = 1'b1;
        4'h5:             op_rd = 1'b1;
        4'h9, 4'hB: begin
          op_rd   = 1'b1;
          op_addr = M_valA;
        end
        default: ;
      endcase
    end
  end

  assign op_mem  = op_rd | op_wr;
  assign addr_ok = (op_addr < 64'(MEM_DEPTH));
  assign start   = op_mem & addr_ok;
  // Ack is only honoured while a request is actually on the bus
  assign ack_hit = (state == BUSY) && mem_req && mem_ack;
  assign to_hit  = (state == BUSY) && !ack_hit && (cnt == TO_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and stall; stall is combinational so the start cycle freezes F/D/E/M
  always_comb begin
    state_nxt = state;
    m_stall   = 1'b0;
    case (state)
      IDLE: begin
        m_stall = start;
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        m_stall = 1'b1;
        if (ack_hit)     state_nxt = DONE;
        else if (to_hit) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request, response capture, timeout counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m_valM     <= '0;
      m_done     <= 1'b0;
      dmem_error <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          m_done <= 1'b0;
          if (start) begin
            mem_req   <= 1'b1;
            mem_read  <= op_rd;
            mem_write <= op_wr;
            mem_addr  <= op_addr;
            mem_wdata <= M_valA;
            cnt       <= '0;
          end else if (op_mem) begin
            // Out-of-range address: flag it and issue nothing
            dmem_error <= 1'b1;
          end
        end
        BUSY: begin
          if (ack_hit) begin
            if (mem_read) m_valM <= mem_rdata;
            mem_req   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            m_done    <= 1'b1;
            cnt       <= '0;
          end else if (to_hit) begin
            mem_req    <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            dmem_error <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: m_done <= 1'b0;
        default: m_done <= 1'b0;
      endcase
    end
  end

endmodule
